// File: rtl/lb_reset_pkg.sv
// Shared constants for the PicoBlaze reset sequencer.
// State encoding, reset-cause codes and a width helper.
package lb_reset_pkg;

  localparam logic [1:0] SYNC    = 2'd0;
  localparam logic [1:0] STRETCH = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic CAUSE_POR = 1'b0;
  localparam logic CAUSE_SW  = 1'b1;

  function automatic int max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lb_reset_sync.sv
// Async-assert / sync-deassert reset synchroniser chain.
// rst_arm is the D input of the last flop (high one edge early).
module lb_reset_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetb,
  output logic rst_sync,
  output logic rst_arm
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = chain[STAGES-1];
  assign rst_arm  = chain[STAGES-2];

endmodule

// File: rtl/lb_reset_sequencer.sv
// Staged multi-domain reset controller with stretch counter
// and a chip-select qualified software reset request.
module lb_reset_sequencer
  import lb_reset_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int STEP_CYCLES    = 8,
  parameter int NUM_OUT        = 4
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               cs,
  input  logic               sw_reset_req,
  output logic [NUM_OUT-1:0] system_reset,
  output logic               reset_done,
  output logic               reset_cause
);

  localparam int CW =
    max(1, $clog2(max(STRETCH_CYCLES, STEP_CYCLES)));
  localparam int IW =
    (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CW-1:0] ST_LAST =
    CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST =
    CW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] ONE = 1;

  logic          rst_sync;
  logic          rst_arm;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          in_sync;
  logic          in_stretch;
  logic          in_release;
  logic          in_done;
  logic          sw_go;

  lb_reset_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .resetb  (resetb),
    .rst_sync(rst_sync),
    .rst_arm (rst_arm)
  );

  assign in_sync    = (state == SYNC);
  assign in_stretch = (state == STRETCH);
  assign in_release = (state == RELEASE);
  assign in_done    = (state == DONE);

  assign sw_go = cs && sw_reset_req && rst_sync &&
                 (in_release || in_done);

  // SYNC exits on the edge rst_sync rises, so that edge is the
  // first stretch cycle and bit 0 falls at SYNC_STAGES+STRETCH.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state        <= SYNC;
      cnt          <= '0;
      idx          <= IW'(1);
      system_reset <= '1;
      reset_done   <= 1'b0;
      reset_cause  <= CAUSE_POR;
    end else if (sw_go) begin
      state        <= STRETCH;
      cnt          <= '0;
      system_reset <= '1;
      reset_done   <= 1'b0;
      reset_cause  <= CAUSE_SW;
    end else begin
      unique case (1'b1)
        in_sync: begin
          if (rst_arm) begin
            state <= STRETCH;
            cnt   <= '0;
          end
        end
        in_stretch: begin
          if (cnt == ST_LAST) begin
            system_reset <= system_reset & ~ONE;
            cnt          <= '0;
            idx          <= IW'(1);
            if (NUM_OUT == 1) begin
              state      <= DONE;
              reset_done <= 1'b1;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        in_release: begin
          if (cnt == STEP_LAST) begin
            system_reset <= system_reset & ~(ONE << idx);
            cnt          <= '0;
            idx          <= idx + IW'(1);
            if (idx == IDX_LAST) begin
              state      <= DONE;
              reset_done <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        in_done: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lb_reset_sequencer.sv
// Scoreboard bench: expected output changes are queued per DUT
// and a negedge monitor pops one entry per observed change.
module tb_lb_reset_sequencer;

  typedef struct {
    int         cyc;
    logic [7:0] sr;
    logic       done;
    logic       cause;
  } exp_t;

  logic clk;
  logic resetb;
  logic resetb2;
  logic cs;
  logic sw_req;
  int   cyc = 0;
  int   asserts = 0;
  int   fails = 0;

  logic [3:0] sr0;
  logic       sr1;
  logic [1:0] sr2;
  logic [7:0] sr3;
  logic [3:0] done_v;
  logic [3:0] cause_v;

  exp_t q[4][$];
  logic [9:0] last[4];

  lb_reset_sequencer u_dut0 (
    .clk(clk), .resetb(resetb), .cs(cs),
    .sw_reset_req(sw_req), .system_reset(sr0),
    .reset_done(done_v[0]), .reset_cause(cause_v[0])
  );

  lb_reset_sequencer #(
    .SYNC_STAGES(3), .STRETCH_CYCLES(1),
    .STEP_CYCLES(1), .NUM_OUT(1)
  ) u_dut1 (
    .clk(clk), .resetb(resetb2), .cs(1'b0),
    .sw_reset_req(1'b0), .system_reset(sr1),
    .reset_done(done_v[1]), .reset_cause(cause_v[1])
  );

  lb_reset_sequencer #(.NUM_OUT(2)) u_dut2 (
    .clk(clk), .resetb(resetb2), .cs(1'b0),
    .sw_reset_req(1'b0), .system_reset(sr2),
    .reset_done(done_v[2]), .reset_cause(cause_v[2])
  );

  lb_reset_sequencer #(.NUM_OUT(8)) u_dut3 (
    .clk(clk), .resetb(resetb2), .cs(1'b0),
    .sw_reset_req(1'b0), .system_reset(sr3),
    .reset_done(done_v[3]), .reset_cause(cause_v[3])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9:0] obs(input int k);
    case (k)
      0: return {done_v[0], cause_v[0], 8'(sr0)};
      1: return {done_v[1], cause_v[1], 8'(sr1)};
      2: return {done_v[2], cause_v[2], 8'(sr2)};
      default: return {done_v[3], cause_v[3], sr3};
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 4; k++) last[k] = 'x;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      logic [9:0] cur;
      exp_t e;
      cur = obs(k);
      if (cur !== last[k]) begin
        last[k] = cur;
        asserts++;
        if (q[k].size() == 0) begin
          fails++;
          $display("FAIL unexpected_change dut%0d cyc=%0d got=%b",
                   k, cyc, cur);
        end else begin
          e = q[k].pop_front();
          if (e.cyc != cyc || cur[7:0] !== e.sr ||
              cur[9] !== e.done || cur[8] !== e.cause) begin
            fails++;
            $display({"FAIL change dut%0d got cyc=%0d sr=%h ",
                      "done=%b cause=%b want cyc=%0d sr=%h ",
                      "done=%b cause=%b"},
                     k, cyc, cur[7:0], cur[9], cur[8],
                     e.cyc, e.sr, e.done, e.cause);
          end
        end
      end
    end
  end

  task automatic push(input int k, input int c,
                      input logic [7:0] sr,
                      input logic d, input logic ca);
    exp_t e;
    e.cyc = c; e.sr = sr; e.done = d; e.cause = ca;
    q[k].push_back(e);
  endtask

  task automatic seq0(input int r, input logic ca);
    push(0, r + 18, 8'h0E, 1'b0, ca);
    push(0, r + 26, 8'h0C, 1'b0, ca);
    push(0, r + 34, 8'h08, 1'b0, ca);
    push(0, r + 42, 8'h00, 1'b1, ca);
  endtask

  task automatic drain(input int k, input int budget);
    int n = 0;
    while (q[k].size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (q[k].size() != 0) begin
      asserts++;
      fails++;
      $display("FAIL timeout dut%0d pending=%0d want=0",
               k, q[k].size());
      q[k].delete();
    end
  endtask

  task automatic check(input string name,
                       input logic [7:0] got,
                       input logic [7:0] want);
    asserts++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int r;
    int n;
    cs = 1'b0;
    sw_req = 1'b0;
    resetb = 1'b1;
    resetb2 = 1'b1;
    push(0, 1, 8'h0F, 1'b0, 1'b0);
    push(1, 1, 8'h01, 1'b0, 1'b0);
    push(2, 1, 8'h03, 1'b0, 1'b0);
    push(3, 1, 8'hFF, 1'b0, 1'b0);
    #1;
    resetb = 1'b0;
    resetb2 = 1'b0;

    // power-on release of all four configurations
    repeat (5) @(posedge clk);
    #1;
    resetb = 1'b1;
    resetb2 = 1'b1;
    r = cyc;
    seq0(r, 1'b0);
    push(1, r + 4, 8'h00, 1'b1, 1'b0);
    push(2, r + 18, 8'h02, 1'b0, 1'b0);
    push(2, r + 26, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      push(3, r + 18 + 8 * i, 8'hFF << (i + 1),
           i == 7, 1'b0);
    for (int k = 0; k < 4; k++) drain(k, 200);
    check("por_done_sr", 8'(sr0), 8'h00);

    // button reset, then async pulse at edge 30
    @(posedge clk);
    #1;
    push(0, cyc, 8'h0F, 1'b0, 1'b0);
    resetb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetb = 1'b1;
    r = cyc;
    push(0, r + 18, 8'h0E, 1'b0, 1'b0);
    push(0, r + 26, 8'h0C, 1'b0, 1'b0);
    wait_to(r + 30);
    check("edge30_sr", 8'(sr0), 8'h0C);
    push(0, cyc, 8'h0F, 1'b0, 1'b0);
    resetb = 1'b0;
    #2;
    resetb = 1'b1;
    r = cyc;
    seq0(r, 1'b0);
    cs = 1'b1;
    sw_req = 1'b1;
    @(posedge clk);
    #1;
    cs = 1'b0;
    sw_req = 1'b0;
    wait_to(r + 10);
    cs = 1'b1;
    sw_req = 1'b1;
    @(posedge clk);
    #1;
    cs = 1'b0;
    sw_req = 1'b0;
    drain(0, 200);

    // request without chip select is ignored
    sw_req = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    sw_req = 1'b0;
    check("nocs_sr", 8'(sr0), 8'h00);
    check("nocs_done", 8'(done_v[0]), 8'h01);
    check("nocs_cause", 8'(cause_v[0]), 8'h00);

    // software reset from DONE
    @(posedge clk);
    #1;
    n = cyc;
    cs = 1'b1;
    sw_req = 1'b1;
    push(0, n + 1, 8'h0F, 1'b0, 1'b1);
    seq0(n - 1, 1'b1);
    @(posedge clk);
    #1;
    cs = 1'b0;
    sw_req = 1'b0;
    drain(0, 200);
    check("sw_cause", 8'(cause_v[0]), 8'h01);

    // button after software reset clears the cause
    @(posedge clk);
    #1;
    push(0, cyc, 8'h0F, 1'b0, 1'b0);
    resetb = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    resetb = 1'b1;
    r = cyc;
    seq0(r, 1'b0);
    drain(0, 200);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
